// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the memory stage (master)
// and the memory responder (slave).
interface dmem_responder_if;
   logic [31:0] daddr;
   logic        dvalid;
   logic        dwrite;
   logic [31:0] dwdata;
   logic [3:0]  dwstb;
   logic        drready;
   logic [31:0] drdata;
   logic        derr;

   modport master (
      output daddr, dvalid, dwrite, dwdata, dwstb,
      input  drready, drdata, derr
   );

   modport slave (
      input  daddr, dvalid, dwrite, dwdata, dwstb,
      output drready, drdata, derr
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-port word RAM answering core data-memory requests. Requests are
// captured on accept, optionally delayed by WAIT_CYCLES, then completed with
// a one-cycle drready pulse. Out-of-range requests complete with derr set.
module dmem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input logic             clock,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
   // One past the last valid byte address; 33 bits so the top of memory never wraps.
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [31:0]   mem [DEPTH];

   logic [1:0]    state_q;
   logic [CW-1:0] cnt_q;
   logic          write_q;
   logic          in_range_q;
   logic [AW-1:0] index_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstb_q;
   logic [31:0]   rdata_q;

   logic          accept;
   logic          in_range_d;
   logic [31:0]   offset;
   logic [AW-1:0] index_d;
   logic          resp;
   logic          addr_unused;

   // Decode the incoming address: range check and word index.
   always_comb begin
      accept     = (state_q == StIdle) && bus.dvalid;
      in_range_d = ({1'b0, bus.daddr} >= {1'b0, BASE_ADDR}) && ({1'b0, bus.daddr} < LIMIT);
      offset     = bus.daddr - BASE_ADDR;
      index_d    = offset[AW+1:2];
   end

   // Byte offset and high offset bits carry no information once range-checked.
   assign addr_unused = ^{offset[1:0], offset[31:2] >> AW};

   // Request sequencing: IDLE -> (WAIT) -> RESP -> IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.dvalid) begin
                  state_q <= (WAIT_CYCLES == 0) ? StResp : StWait;
                  cnt_q   <= '0;
               end
            end
            StWait: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= StResp;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Capture the request and the read data at the accept edge.
   always_ff @(posedge clock) begin
      if (accept) begin
         write_q    <= bus.dwrite;
         in_range_q <= in_range_d;
         index_q    <= index_d;
         wdata_q    <= bus.dwdata;
         wstb_q     <= bus.dwstb;
         rdata_q    <= in_range_d ? mem[index_d] : '0;
      end
   end

   // Commit a write on the edge that ends RESP; a reset on that edge abandons it.
   always_ff @(posedge clock) begin
      if (!reset && resp && write_q && in_range_q) begin
         for (int i = 0; i < 4; i++) begin
            if (wstb_q[i]) begin
               mem[index_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   // Response outputs are driven only during RESP and read as zero otherwise.
   always_comb begin
      resp        = (state_q == StResp);
      bus.drready = resp;
      bus.derr    = resp && !in_range_q;
      bus.drdata  = (resp && !write_q && in_range_q) ? rdata_q : '0;
   end

endmodule
